// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: redirect/stall controls and instruction memory data in,
// fetch address and IF/ID pipeline register contents out.
interface instruction_fetch_if;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [31:0] instr_in;
   logic [63:0] pc;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;
   logic [31:0] fetch_count;
   logic        misalign;

   // master: the fetch unit itself
   modport master (
      input  stall, branch_taken, branch_target, instr_in,
      output pc, if_id_pc, if_id_instr, if_id_valid, fetch_count, misalign
   );

   // slave: the pipeline/memory side that steers fetch and consumes IF/ID
   modport slave (
      output stall, branch_taken, branch_target, instr_in,
      input  pc, if_id_pc, if_id_instr, if_id_valid, fetch_count, misalign
   );
endinterface

// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch: PC register feeding a zero-latency memory and
// the IF/ID register. Optional FETCH_ALIGN_CHECK_EN aligns redirects and flags misalignment.
module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   instruction_fetch_if.master        bus
);

   logic [63:0] pc_q, pc_d;
   logic [63:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [63:0] redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign redirect_pc = {bus.branch_target[63:2], 2'b00};

   always_comb begin
      misalign_d = misalign_q;
      if (bus.branch_taken && (bus.branch_target[1:0] != 2'b00)) begin
         misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign bus.misalign = misalign_q;
`else
   assign redirect_pc  = bus.branch_target;
   assign bus.misalign = 1'b0;
`endif

   // Redirect beats stall; the word at pc during a redirect is dropped.
   always_comb begin
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      fetch_count_d = fetch_count_q;
      if (bus.branch_taken) begin
         pc_d          = redirect_pc;
         if_id_pc_d    = 64'h0;
         if_id_instr_d = 32'h0;
         if_id_valid_d = 1'b0;
      end else if (!bus.stall) begin
         pc_d          = pc_q + 64'd4;
         if_id_pc_d    = pc_q;
         if_id_instr_d = bus.instr_in;
         if_id_valid_d = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 64'h0;
         if_id_instr_q <= 32'h0;
         if_id_valid_q <= 1'b0;
         fetch_count_q <= 32'h0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.if_id_pc    = if_id_pc_q;
   assign bus.if_id_instr = if_id_instr_q;
   assign bus.if_id_valid = if_id_valid_q;
   assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a reference model pushes the expected
// post-edge state per cycle; each edge's DUT outputs are popped and compared.
module tb_instruction_fetch;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instruction_fetch_if bus ();

   instruction_fetch #(.RESET_PC(64'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B9) ^ 32'h1357_9BDF ^ a[63:32];
   endfunction

   assign bus.instr_in = mem_word(bus.pc);

   typedef struct {
      logic [63:0] pc;
      logic [63:0] ifpc;
      logic [31:0] instr;
      logic        vld;
      logic [31:0] cnt;
      logic        mis;
   } exp_t;

   exp_t sb[$];

   logic [63:0] m_pc;
   logic [63:0] m_ifpc;
   logic [31:0] m_instr;
   logic        m_vld;
   logic [31:0] m_cnt;
   logic        m_mis;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_result();
      exp_t e;
      if (sb.size() == 0) begin
         check_val("sb_empty", 64'd0, 64'd1);
         return;
      end
      e = sb.pop_front();
      check_val("pc",          bus.pc,                 e.pc);
      check_val("if_id_pc",    bus.if_id_pc,           e.ifpc);
      check_val("if_id_instr", {32'h0, bus.if_id_instr}, {32'h0, e.instr});
      check_val("if_id_valid", {63'h0, bus.if_id_valid}, {63'h0, e.vld});
      check_val("fetch_count", {32'h0, bus.fetch_count}, {32'h0, e.cnt});
      check_val("misalign",    {63'h0, bus.misalign},  {63'h0, e.mis});
   endtask

   // One clock: drive at negedge, model the edge, push, then compare after the edge.
   task automatic drive(input logic st, input logic br, input logic [63:0] tgt, input logic rn);
      exp_t e;
      @(negedge clk);
      rst_n             = rn;
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = tgt;
      if (!rn) begin
         m_pc = 64'h0; m_ifpc = 64'h0; m_instr = 32'h0; m_vld = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;
      end else if (br) begin
`ifdef FETCH_ALIGN_CHECK_EN
         if (tgt[1:0] != 2'b00) m_mis = 1'b1;
         m_pc = tgt & ~64'h3;
`else
         m_pc = tgt;
`endif
         m_ifpc = 64'h0; m_instr = 32'h0; m_vld = 1'b0;
      end else if (!st) begin
         m_ifpc  = m_pc;
         m_instr = mem_word(m_pc);
         m_vld   = 1'b1;
         m_cnt   = m_cnt + 32'd1;
         m_pc    = m_pc + 64'd4;
      end
      e.pc = m_pc; e.ifpc = m_ifpc; e.instr = m_instr; e.vld = m_vld; e.cnt = m_cnt; e.mis = m_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_result();
   endtask

   initial begin
      rst_n = 1'b0;
      bus.stall = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_target = 64'h0;
      m_pc = 64'h0; m_ifpc = 64'h0; m_instr = 32'h0; m_vld = 1'b0; m_cnt = 32'h0; m_mis = 1'b0;

      // reset, including reset overriding a simultaneous redirect and stall
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      drive(1'b1, 1'b1, 64'h80, 1'b0);
      check_val("reset_pc", bus.pc, 64'h0);
      check_val("reset_valid", {63'h0, bus.if_id_valid}, 64'h0);

      // four sequential fetches from RESET_PC
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 64'h0, 1'b1);
         check_val("seq_pc", bus.pc, 64'(4 * (i + 1)));
         check_val("seq_ifpc", bus.if_id_pc, 64'(4 * i));
      end
      check_val("seq_count", {32'h0, bus.fetch_count}, 64'd4);

      // stall three cycles at pc=8
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 64'h0, 1'b1);
         check_val("stall_pc", bus.pc, 64'h8);
         check_val("stall_cnt", {32'h0, bus.fetch_count}, 64'd2);
      end
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      check_val("resume_pc", bus.pc, 64'hC);
      check_val("resume_ifpc", bus.if_id_pc, 64'h8);

      // redirect from pc=8 to 0x40
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      drive(1'b0, 1'b1, 64'h40, 1'b1);
      check_val("br_pc", bus.pc, 64'h40);
      check_val("br_valid", {63'h0, bus.if_id_valid}, 64'h0);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      check_val("br_ifpc", bus.if_id_pc, 64'h40);
      check_val("br_valid2", {63'h0, bus.if_id_valid}, 64'h1);
      check_val("br_instr", {32'h0, bus.if_id_instr}, {32'h0, mem_word(64'h40)});

      // redirect overrides stall
      drive(1'b1, 1'b1, 64'h100, 1'b1);
      check_val("brst_pc", bus.pc, 64'h100);
      check_val("brst_valid", {63'h0, bus.if_id_valid}, 64'h0);

      // pc wrap at top of address space
      drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      check_val("pc_wrap", bus.pc, 64'h0);
      check_val("pc_wrap_ifpc", bus.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // fetch_count wrap: preload the counter, then capture once
      force dut.fetch_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_count_q;
      m_cnt = 32'hFFFF_FFFF;
      check_val("cnt_preload", {32'h0, bus.fetch_count}, 64'hFFFF_FFFF);
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      check_val("cnt_wrap", {32'h0, bus.fetch_count}, 64'h0);

      // misaligned redirect
      drive(1'b0, 1'b1, 64'h42, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
      check_val("mis_pc", bus.pc, 64'h40);
      check_val("mis_flag", {63'h0, bus.misalign}, 64'h1);
`else
      check_val("mis_pc", bus.pc, 64'h42);
      check_val("mis_flag", {63'h0, bus.misalign}, 64'h0);
`endif
      drive(1'b0, 1'b0, 64'h0, 1'b1);
      drive(1'b1, 1'b0, 64'h0, 1'b1);
      drive(1'b0, 1'b1, 64'h200, 1'b1);
      drive(1'b0, 1'b0, 64'h0, 1'b0);
      check_val("mis_clear", {63'h0, bus.misalign}, 64'h0);

      // randomized mix of fetch, stall and aligned redirects
      for (int i = 0; i < 60; i++) begin
         logic st, br;
         logic [63:0] tgt;
         st  = ($urandom_range(0, 3) == 0);
         br  = ($urandom_range(0, 5) == 0);
         tgt = {$urandom(), $urandom()} & ~64'h3;
         drive(st, br, tgt, ($urandom_range(0, 29) != 0));
      end

      check_val("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
